// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the fetch front end: sequencer state encoding and the decode queue entry.
package fetch_sequencer_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with wrapping pointers and a synchronous clear; the head word is read combinationally.
module fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full queue still takes a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count alone define which words are valid.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch front end: issues imem requests at npc, tracks in-flight responses, buffers {inst, pc}
// for decode, and discards stale work after late (ALU) or early (decode) redirects.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int QUEUE_DEPTH     = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] npc,
  input  logic            br_late,
  input  logic            br_late_done,
  input  logic            early_redirect,
  output logic            fetch_stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] inst_feedback,
  output logic            dec_valid,
  output logic [XLEN-1:0] dec_inst,
  output logic [XLEN-1:0] dec_pc,
  input  logic            dec_ready
);

  localparam int QCW = $clog2(QUEUE_DEPTH) + 1;
  localparam int OCW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int SCW = QCW + OCW;

  fetch_state_e    state;
  logic [OCW-1:0]  outstanding;
  logic [OCW-1:0]  outstanding_nxt;
  logic [OCW-1:0]  kill_cnt;
  logic [OCW-1:0]  kill_nxt;
  logic [OCW-1:0]  live_outstanding;
  logic [SCW-1:0]  credit_used;
  logic [QCW-1:0]  q_count;
  logic            q_empty;
  logic            q_full;
  logic            q_push;
  logic            q_pop;
  fetch_entry_t    q_head;
  fetch_entry_t    q_din;
  logic [XLEN-1:0] pend_pc;
  logic            pend_empty;
  logic            pend_full;
  logic [OCW-1:0]  pend_count;
  logic            redirect;
  logic            issue_state;
  logic            accept;
  logic            resp;
  logic            unused_ok;

  assign redirect    = br_late | early_redirect;
  assign issue_state = (state == ST_RUN) || (state == ST_DRAIN);
  assign resp        = imem_rvalid & (outstanding != '0);
  assign accept      = imem_req & imem_gnt;

  // Credits: queued entries plus responses still destined for the queue never exceed its depth.
  assign live_outstanding = outstanding - kill_cnt;
  assign credit_used      = SCW'(q_count) + SCW'(live_outstanding);

  assign imem_req = issue_state & ~redirect
                  & (outstanding < OCW'(MAX_OUTSTANDING))
                  & (credit_used < SCW'(QUEUE_DEPTH));
  assign imem_addr     = npc;
  assign fetch_stall   = ~accept;
  assign inst_feedback = imem_rdata;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    outstanding_nxt = outstanding;
    case ({accept, resp})
      2'b10:   outstanding_nxt = outstanding + 1'b1;
      2'b01:   outstanding_nxt = outstanding - 1'b1;
      default: ;
    endcase
    kill_nxt = kill_cnt;
    if (redirect) kill_nxt = outstanding_nxt;
    else if (resp && (kill_cnt != '0)) kill_nxt = kill_cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_HOLD;
      outstanding <= '0;
      kill_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      kill_cnt    <= kill_nxt;
      if (redirect) begin
        state <= ST_FLUSH;
      end else begin
        case (state)
          ST_HOLD:  state <= ST_RUN;
          ST_RUN:   state <= ST_RUN;
          ST_FLUSH: state <= (kill_nxt != '0) ? ST_DRAIN : ST_RUN;
          ST_DRAIN: state <= (kill_nxt == '0) ? ST_RUN : ST_DRAIN;
          default:  state <= ST_HOLD;
        endcase
      end
    end
  end

  // A response in a redirect cycle is stale along with everything older than the redirect.
  assign q_push = resp & (kill_cnt == '0) & ~redirect;
  assign q_pop  = dec_valid & dec_ready;
  assign q_din  = '{inst: imem_rdata, pc: pend_pc};

  fetch_queue #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_pend_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .push  (accept),
    .din   (imem_addr),
    .pop   (resp),
    .dout  (pend_pc),
    .empty (pend_empty),
    .full  (pend_full),
    .count (pend_count)
  );

  fetch_queue #(.WIDTH(2 * XLEN), .DEPTH(QUEUE_DEPTH)) u_inst_queue (
    .clk   (clk),
    .rst   (rst),
    .clr   (redirect),
    .push  (q_push),
    .din   (q_din),
    .pop   (q_pop),
    .dout  (q_head),
    .empty (q_empty),
    .full  (q_full),
    .count (q_count)
  );

  assign dec_valid = ~q_empty;
  assign dec_inst  = dec_valid ? q_head.inst : '0;
  assign dec_pc    = dec_valid ? q_head.pc   : '0;

  // br_late_done needs no action: npc already carries the target, so issue proceeds normally.
  assign unused_ok = ^{br_late_done, q_full, pend_empty, pend_full, pend_count};

  a_no_orphan_rvalid : assert property (@(posedge clk) disable iff (!rst)
    imem_rvalid |-> (outstanding != '0));

endmodule
